// File: rtl/pool_frame_loader.sv
// Serial-to-parallel frame loader: assembles an input_size x input_size frame
// from a valid/ready word stream and holds it until downstream consumes it.
module pool_frame_loader #(
  parameter int input_size = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] frame_data [input_size*input_size-1:0],
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic        frame_err,
  input  logic        err_clr
);

  localparam int N     = input_size * input_size;
  localparam int CNT_W = (N > 2) ? $clog2(N) : 1;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  logic [0:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             err_reg, err_next;
  // Holds in_ready low until the first clock edge after reset is released.
  logic             live_reg;

  logic accept;
  logic at_last_slot;
  logic err_set;

  assign in_ready    = live_reg & (state_reg == ST_FILL);
  assign frame_valid = (state_reg == ST_HOLD);
  assign frame_err   = err_reg;

  assign accept       = in_valid & in_ready;
  assign at_last_slot = (cnt_reg == LAST_IDX);
  // Early in_last and missing in_last are both a disagreement between the
  // beat position and the in_last marker.
  assign err_set      = accept & (at_last_slot ^ in_last);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;

    if (state_reg == ST_FILL) begin
      if (accept) begin
        if (at_last_slot) begin
          cnt_next   = '0;
          state_next = ST_HOLD;
        end else if (in_last) begin
          cnt_next = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
    end else begin
      if (frame_ready) begin
        state_next = ST_FILL;
      end
    end

    if (err_set) begin
      err_next = 1'b1;
    end else if (err_clr) begin
      err_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_FILL;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
      live_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
      live_reg  <= 1'b1;
    end
  end

  // One register per frame slot; only the slot addressed by the counter loads.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_word
      logic [31:0] word_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          word_reg <= '0;
        end else if (accept && (cnt_reg == CNT_W'(gi))) begin
          word_reg <= in_data;
        end
      end

      assign frame_data[gi] = word_reg;
    end
  endgenerate

endmodule

// File: tb/tb_pool_frame_loader.sv
// Self-checking bench for pool_frame_loader: vector tables, directed corner
// sequences and a randomized phase against a queue-based frame model.
module tb_pool_frame_loader;

  localparam int IS = 4;
  localparam int N  = IS * IS;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] frame_data [N-1:0];
  logic        frame_valid;
  logic        frame_ready;
  logic        frame_err;
  logic        err_clr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pool_frame_loader #(.input_size(IS)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .frame_err  (frame_err),
    .err_clr    (err_clr)
  );

  // Reference model: the words of the frame in progress live in a queue;
  // the presented image is a plain array.
  logic [31:0] m_img [N];
  logic [31:0] m_fill [$];
  bit          m_hold;
  bit          m_err;
  bit          m_live;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        l;
    logic        fr;
    logic        ec;
    logic        e_rdy;
    logic        e_fv;
    logic        e_err;
  } vec_t;

  vec_t vt [$];

  task automatic model_reset();
    foreach (m_img[i]) m_img[i] = '0;
    m_fill.delete();
    m_hold = 0;
    m_err  = 0;
    m_live = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_edge();
    bit acc;
    bit set_err;
    acc     = in_valid && m_live && !m_hold;
    set_err = 0;
    if (acc) begin
      m_img[m_fill.size()] = in_data;
      m_fill.push_back(in_data);
      if (m_fill.size() == N) begin
        m_hold  = 1;
        set_err = !in_last;
        m_fill.delete();
      end else if (in_last) begin
        set_err = 1;
        m_fill.delete();
      end
    end else if (m_hold && frame_ready) begin
      m_hold = 0;
    end
    if (set_err) m_err = 1;
    else if (err_clr) m_err = 0;
    m_live = 1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_model(string tag);
    int bad_i;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(m_live && !m_hold));
    chk({tag, ".frame_valid"}, 32'(frame_valid), 32'(m_hold));
    chk({tag, ".frame_err"}, 32'(frame_err), 32'(m_err));
    bad_i = -1;
    for (int i = N - 1; i >= 0; i--) begin
      if (frame_data[i] !== m_img[i]) bad_i = i;
    end
    n_cmp++;
    if (bad_i >= 0) begin
      n_bad++;
      $display("FAIL %s.frame_data[%0d]: got %h expected %h", tag, bad_i,
               frame_data[bad_i], m_img[bad_i]);
    end
  endtask

  task automatic cycle(logic v, logic [31:0] d, logic l, logic fr, logic ec,
                       string tag);
    in_valid    = v;
    in_data     = d;
    in_last     = l;
    frame_ready = fr;
    err_clr     = ec;
    model_edge();
    @(posedge clk);
    #1;
    chk_model(tag);
  endtask

  task automatic idle_inputs();
    in_valid    = 0;
    in_data     = '0;
    in_last     = 0;
    frame_ready = 0;
    err_clr     = 0;
  endtask

  task automatic do_reset(string tag);
    rst = 1;
    #1;
    model_reset();
    chk_model({tag, ".async"});
    idle_inputs();
    @(posedge clk);
    #1;
    chk_model({tag, ".held"});
    rst = 0;
    cycle(0, '0, 0, 0, 0, {tag, ".release"});
    chk({tag, ".ready_up"}, 32'(in_ready), 32'd1);
  endtask

  task automatic send_frame(logic [31:0] base, int count, bit last_at_end,
                            string tag);
    for (int i = 0; i < count; i++) begin
      cycle(1, base + 32'(i), last_at_end && (i == count - 1), 0, 0, tag);
    end
  endtask

  initial begin
    int acc;
    int budget;
    logic v;
    logic l;

    rst = 1;
    idle_inputs();
    model_reset();
    #1;
    chk_model("reset0");
    @(posedge clk);
    #1;
    rst = 0;
    cycle(0, '0, 0, 0, 0, "first_edge");
    chk("first_edge.in_ready", 32'(in_ready), 32'd1);

    // Basic fill, then backpressure in HOLD, then a one-cycle consume.
    for (int i = 0; i < N; i++)
      vt.push_back('{v: 1, d: 32'(i + 1), l: (i == N - 1), fr: 0, ec: 0,
                     e_rdy: (i != N - 1), e_fv: (i == N - 1), e_err: 0});
    for (int i = 0; i < 5; i++)
      vt.push_back('{v: 1, d: 32'hDEADBEEF, l: 0, fr: 0, ec: 0,
                     e_rdy: 0, e_fv: 1, e_err: 0});
    vt.push_back('{v: 0, d: 0, l: 0, fr: 1, ec: 0, e_rdy: 1, e_fv: 0, e_err: 0});

    for (int i = 0; i < vt.size(); i++) begin
      cycle(vt[i].v, vt[i].d, vt[i].l, vt[i].fr, vt[i].ec, "vec");
      chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(vt[i].e_rdy));
      chk($sformatf("vec%0d.frame_valid", i), 32'(frame_valid), 32'(vt[i].e_fv));
      chk($sformatf("vec%0d.frame_err", i), 32'(frame_err), 32'(vt[i].e_err));
      if (i == N - 1) begin
        chk("basic.fd0", frame_data[0], 32'd1);
        chk("basic.fd5", frame_data[5], 32'd6);
        chk("basic.fd15", frame_data[15], 32'd16);
      end
      if (i == N + 4) begin
        for (int k = 0; k < N; k++)
          chk($sformatf("hold.fd%0d", k), frame_data[k], 32'(k + 1));
      end
    end

    // Second frame after consume.
    send_frame(32'd101, N, 1, "frame2");
    chk("frame2.fd0", frame_data[0], 32'd101);
    chk("frame2.fd15", frame_data[15], 32'd116);
    cycle(0, '0, 0, 1, 0, "frame2.consume");

    // Gapped input.
    acc = 0;
    budget = 0;
    while (acc < N && budget < 200) begin
      v = 1'($urandom_range(0, 1));
      if (v) acc++;
      cycle(v, 32'(acc), v && (acc == N), 0, 0, "gap");
      if (acc < N) chk("gap.fv_low", 32'(frame_valid), 32'd0);
      budget++;
    end
    chk("gap.budget", 32'(acc), 32'(N));
    chk("gap.fv_rise", 32'(frame_valid), 32'd1);
    for (int k = 0; k < N; k++)
      chk($sformatf("gap.fd%0d", k), frame_data[k], 32'(k + 1));
    cycle(0, '0, 0, 1, 0, "gap.consume");

    // Early in_last aborts the frame and sets the sticky error.
    send_frame(32'd1, 7, 1, "early");
    chk("early.err", 32'(frame_err), 32'd1);
    chk("early.fill", 32'(in_ready), 32'd1);
    chk("early.fv", 32'(frame_valid), 32'd0);
    send_frame(32'd201, N, 1, "after_early");
    chk("after_early.fd0", frame_data[0], 32'd201);
    chk("after_early.fd15", frame_data[15], 32'd216);
    chk("after_early.err_sticky", 32'(frame_err), 32'd1);
    cycle(0, '0, 0, 1, 0, "after_early.consume");
    chk("after_early.err_still", 32'(frame_err), 32'd1);
    cycle(0, '0, 0, 0, 1, "err_clr");
    chk("err_clr.err", 32'(frame_err), 32'd0);

    // Missing in_last still presents the frame, with the error flagged.
    send_frame(32'd401, N, 0, "missing");
    chk("missing.fv", 32'(frame_valid), 32'd1);
    chk("missing.err", 32'(frame_err), 32'd1);
    cycle(0, '0, 0, 1, 0, "missing.consume");
    cycle(0, '0, 0, 0, 1, "missing.clr");
    chk("missing.clr", 32'(frame_err), 32'd0);
    send_frame(32'd501, 3, 0, "setwin");
    cycle(1, 32'd504, 1, 0, 1, "setwin.collide");
    chk("setwin.err", 32'(frame_err), 32'd1);

    // Asynchronous reset after 9 accepted words.
    send_frame(32'd601, 9, 0, "pre_rst");
    #2;
    do_reset("midrst");
    for (int k = 0; k < N; k++)
      chk($sformatf("midrst.zero%0d", k), frame_data[k], 32'd0);
    send_frame(32'd701, N, 1, "post_rst");
    for (int k = 0; k < N; k++)
      chk($sformatf("post_rst.fd%0d", k), frame_data[k], 32'(701 + k));
    chk("post_rst.err", 32'(frame_err), 32'd0);
    cycle(0, '0, 0, 1, 0, "post_rst.consume");

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      if (m_fill.size() == N - 1) l = 1'($urandom_range(0, 7) != 0);
      else l = 1'($urandom_range(0, 15) == 0);
      cycle(1'($urandom_range(0, 3) != 0), $urandom, l,
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
